// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet II header parser.
package eth_pkg;

  // Parser states: header bytes, optional 802.1Q tag, header handshake, payload forwarding.
  typedef enum logic [1:0] {
    S_HDR     = 2'd0,
    S_VLAN    = 2'd1,
    S_HOLD    = 2'd2,
    S_PAYLOAD = 2'd3
  } state_t;

  localparam int          ETH_HDR_LEN  = 14;
  localparam int          VLAN_TAG_LEN = 4;
  localparam logic [15:0] TPID_8021Q   = 16'h8100;

  // Parsed header as presented on the hdr_* sideband.
  typedef struct packed {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] etype;
    logic        vlan_present;
    logic [15:0] tci;
  } eth_hdr_t;

endpackage

// File: rtl/sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;

  // Count one event per cycle, holding once every bit is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {CNT_W{1'b1}})) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/eth_hdr_parser.sv
// Ethernet II header parser: strips dst/src/(802.1Q)/EtherType from a byte
// stream, offers them on a valid/ready sideband, then forwards the payload.
module eth_hdr_parser
  import eth_pkg::*;
#(
  parameter int VLAN_EN    = 1,
  parameter int USER_WIDTH = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  input  logic [USER_WIDTH-1:0] s_tuser,
  output logic [7:0]            m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic [USER_WIDTH-1:0] m_tuser,
  output logic                  hdr_valid,
  input  logic                  hdr_ready,
  output logic [47:0]           hdr_dst_mac,
  output logic [47:0]           hdr_src_mac,
  output logic [15:0]           hdr_ethertype,
  output logic                  hdr_vlan_present,
  output logic [15:0]           hdr_vlan_tci,
  output logic                  hdr_no_payload,
  output logic                  err_runt,
  output logic [CNT_W-1:0]      stat_frames,
  output logic [CNT_W-1:0]      stat_runts
);

  localparam logic [3:0] HDR_LAST = 4'(ETH_HDR_LEN - 1);
  localparam logic [3:0] TAG_LAST = 4'(VLAN_TAG_LEN - 1);

  state_t     state_reg;
  logic [3:0] cnt_reg;
  eth_hdr_t   hdr_reg;
  logic       hdr_valid_reg;
  logic       no_payload_reg;
  logic       err_runt_reg;

  logic        s_acc;
  logic [15:0] etype_next;
  logic        is_tag;
  logic        runt_det;
  logic [1:0]  stat_inc;
  logic [CNT_W-1:0] stat_val [2];

  // Input is open while collecting header bytes, follows the sink during payload, closed in hold.
  always_comb begin
    s_tready = 1'b0;
    case (state_reg)
      S_HDR, S_VLAN: s_tready = 1'b1;
      S_PAYLOAD:     s_tready = m_tready;
      default:       s_tready = 1'b0;
    endcase
  end

  assign s_acc      = s_tvalid && s_tready;
  assign etype_next = {hdr_reg.etype[7:0], s_tdata};
  assign is_tag     = (VLAN_EN != 0) && (etype_next == TPID_8021Q);

  // A frame that ends before its header is complete; a tag announced on the
  // very last untagged byte also counts, since the tag bytes never arrive.
  assign runt_det = s_acc && s_tlast &&
                    (((state_reg == S_HDR) && ((cnt_reg != HDR_LAST) || is_tag)) ||
                     ((state_reg == S_VLAN) && (cnt_reg != TAG_LAST)));

  // Parser FSM: shifts header bytes into their fields and sequences the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_HDR;
      cnt_reg        <= '0;
      hdr_reg        <= '0;
      hdr_valid_reg  <= 1'b0;
      no_payload_reg <= 1'b0;
      err_runt_reg   <= 1'b0;
    end else begin
      err_runt_reg <= runt_det;
      case (state_reg)
        S_HDR: begin
          if (s_acc) begin
            // First byte of a new frame: drop tag info left over from the previous one.
            if (cnt_reg == 4'd0) begin
              hdr_reg.vlan_present <= 1'b0;
              hdr_reg.tci          <= '0;
              no_payload_reg       <= 1'b0;
            end
            if (cnt_reg < 4'd6) begin
              hdr_reg.dst <= {hdr_reg.dst[39:0], s_tdata};
            end else if (cnt_reg < 4'd12) begin
              hdr_reg.src <= {hdr_reg.src[39:0], s_tdata};
            end else begin
              hdr_reg.etype <= etype_next;
            end
            if (runt_det) begin
              cnt_reg <= '0;
            end else if (cnt_reg == HDR_LAST) begin
              cnt_reg <= '0;
              if (is_tag) begin
                hdr_reg.vlan_present <= 1'b1;
                state_reg            <= S_VLAN;
              end else begin
                hdr_valid_reg  <= 1'b1;
                no_payload_reg <= s_tlast;
                state_reg      <= S_HOLD;
              end
            end else begin
              cnt_reg <= cnt_reg + 4'd1;
            end
          end
        end
        S_VLAN: begin
          if (s_acc) begin
            // Tag bytes 0-1 are the TCI; bytes 2-3 overwrite the type with the inner EtherType.
            if (cnt_reg < 4'd2) begin
              hdr_reg.tci <= {hdr_reg.tci[7:0], s_tdata};
            end else begin
              hdr_reg.etype <= etype_next;
            end
            if (runt_det) begin
              cnt_reg   <= '0;
              state_reg <= S_HDR;
            end else if (cnt_reg == TAG_LAST) begin
              cnt_reg        <= '0;
              hdr_valid_reg  <= 1'b1;
              no_payload_reg <= s_tlast;
              state_reg      <= S_HOLD;
            end else begin
              cnt_reg <= cnt_reg + 4'd1;
            end
          end
        end
        S_HOLD: begin
          if (hdr_ready) begin
            hdr_valid_reg <= 1'b0;
            state_reg     <= no_payload_reg ? S_HDR : S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (s_acc && s_tlast) begin
            cnt_reg   <= '0;
            state_reg <= S_HDR;
          end
        end
        default: state_reg <= S_HDR;
      endcase
    end
  end

  // Payload is a straight wire-through; only valid is gated by the state.
  assign m_tdata  = s_tdata;
  assign m_tlast  = s_tlast;
  assign m_tuser  = s_tuser;
  assign m_tvalid = (state_reg == S_PAYLOAD) && s_tvalid;

  assign hdr_valid        = hdr_valid_reg;
  assign hdr_dst_mac      = hdr_reg.dst;
  assign hdr_src_mac      = hdr_reg.src;
  assign hdr_ethertype    = hdr_reg.etype;
  assign hdr_vlan_present = hdr_reg.vlan_present;
  assign hdr_vlan_tci     = hdr_reg.tci;
  assign hdr_no_payload   = no_payload_reg;
  assign err_runt         = err_runt_reg;

  // Index 0 counts accepted headers, index 1 counts runts.
  assign stat_inc[0] = hdr_valid_reg && hdr_ready;
  assign stat_inc[1] = runt_det;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_stat
      sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stat_inc[gi]),
        .count (stat_val[gi])
      );
    end
  endgenerate

  assign stat_frames = stat_val[0];
  assign stat_runts  = stat_val[1];

endmodule

// File: doc/eth_hdr_parser.md
Name: eth_hdr_parser

Overview:
- Consumes the byte-wide AXI-Stream frame leaving the ingress skid buffer.
- Extracts the Ethernet II header: destination MAC, source MAC, optional single 802.1Q tag, and EtherType.
- Presents the header on a valid/ready sideband, then forwards the payload bytes on a downstream AXI-Stream port.
- Sits between the ingress skid buffer and the L3 dispatch stage.

Parameters:
- VLAN_EN, 1, 1 = parse one 802.1Q tag (TPID 0x8100); 0 = treat 0x8100 as a plain EtherType.
- USER_WIDTH, 1, width of the tuser sideband; bit 0 means frame error.
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- s_tdata  in  8  input frame byte
- s_tvalid  in  1  input valid
- s_tready  out  1  input ready
- s_tlast  in  1  last byte of frame
- s_tuser  in  USER_WIDTH  sideband; sampled on the s_tlast beat
- m_tdata  out  8  payload byte
- m_tvalid  out  1  payload valid
- m_tready  in  1  payload ready
- m_tlast  out  1  last payload byte
- m_tuser  out  USER_WIDTH  s_tuser of the last beat, valid with m_tlast
- hdr_valid  out  1  header fields valid
- hdr_ready  in  1  header accepted
- hdr_dst_mac  out  48  destination MAC (first byte on the wire = bits 47:40)
- hdr_src_mac  out  48  source MAC
- hdr_ethertype  out  16  EtherType; the inner type when tagged
- hdr_vlan_present  out  1  802.1Q tag parsed
- hdr_vlan_tci  out  16  tag control info; 0 when untagged
- hdr_no_payload  out  1  frame ended on the final header byte
- err_runt  out  1  one-cycle pulse: frame ended before the header was complete
- stat_frames  out  CNT_W  headers accepted on hdr_ready, saturating
- stat_runts  out  CNT_W  runt frames, saturating

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. On reset, state = S_HDR, byte counter = 0, all hdr_* = 0, m_tvalid = 0, err_runt = 0, stats = 0.
- s_tready = 1 in S_HDR and S_VLAN; = m_tready in S_PAYLOAD; = 0 in S_HOLD.
- All outputs except s_tready and the m_* passthrough are registered.
- S_HDR:
  - Each accepted byte shifts into the field selected by byte counter 0..13: 0-5 dst, 6-11 src, 12-13 type.
  - On byte 13: if VLAN_EN and type == 0x8100, set vlan_present and go to S_VLAN; otherwise go to S_HOLD.
- S_VLAN: bytes 0-1 = TCI, bytes 2-3 = inner EtherType; after byte 3 go to S_HOLD.
- S_HOLD:
  - hdr_valid = 1 with fields stable; input is stalled.
  - On hdr_valid && hdr_ready: increment stat_frames; go to S_PAYLOAD, or to S_HDR if hdr_no_payload.
  - Header latency: hdr_valid rises the cycle after the last header byte is accepted.
- S_PAYLOAD:
  - Combinational passthrough: m_tdata/m_tvalid/m_tlast/m_tuser = s_*; s_tready = m_tready.
  - On an accepted beat with s_tlast, return to S_HDR and clear the byte counter.
- hdr_no_payload: set when s_tlast arrives on the final header byte (byte 13 untagged, or tag byte 3). The s_tuser sampled on that beat is dropped.
- Runt: s_tlast accepted on any header byte before the final one:
  - err_runt pulses for 1 cycle and stat_runts increments.
  - No hdr_valid is raised; return to S_HDR with the counter cleared.
  - The hdr_* registers may hold partial data but must not be qualified.
- Back-to-back frames: a new frame's first byte may be accepted the cycle after the previous frame's last payload beat.
- Input stalls (s_tvalid = 0) in any state hold the state and counter unchanged.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-frame: returns immediately to the reset state; the remainder of the interrupted frame is parsed as a new frame (upstream is flushed by the same reset).

Decomposition:
- eth_pkg: state enum {S_HDR, S_VLAN, S_HOLD, S_PAYLOAD}, ETH_HDR_LEN = 14, VLAN_TAG_LEN = 4, TPID_8021Q = 16'h8100, and an eth_hdr_t packed struct (dst, src, type, vlan_present, tci).
- One sub-module: sat_counter (CNT_W, inc -> count), instantiated twice.

Test Plan:
- Untagged frame (dst 01:02:03:04:05:06, src 0A:0B:0C:0D:0E:0F, type 0x0800, 4 payload bytes AA BB CC DD, tuser = 1 on last), hdr_ready = 1 -> header fields as given, vlan_present = 0, m stream AA..DD with m_tlast on DD and m_tuser = 1, stat_frames = 1.
- Tagged frame (type 0x8100, TCI 0x6064, inner 0x86DD, 2 payload bytes), VLAN_EN = 1 -> vlan_present = 1, tci = 0x6064, ethertype = 0x86DD, 2 payload beats. With VLAN_EN = 0 -> ethertype = 0x8100 and 6 payload beats.
- hdr_ready held 0 for 5 cycles -> hdr_valid stays 1, s_tready = 0 throughout, no m_tvalid, fields stable.
- 9-byte frame with tlast on byte 8 -> err_runt pulses once, stat_runts = 1, no hdr_valid; the following good frame parses correctly.
- 14-byte frame -> hdr_no_payload = 1 and no m beats. Random m_tready/s_tvalid gaps on a 64-byte payload -> exact byte order preserved with no duplication or loss.
- Reset asserted during payload byte 10 -> all outputs return to reset values; the next frame parses normally.
